// File: rtl/multicycle_sequencer_pkg.sv
// Shared processor package: sequencer state encodings,
// default timeout/counter widths and a small state helper.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int COUNT_WIDTH_DEF = 32;

  // States that wait on memReady and are guarded by the timer.
  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMORY);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer control bundle: decode/memory inputs, enables,
// status and counters. master = sequencer, slave = datapath.
interface multicycle_sequencer_if
  import multicycle_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) ();

  logic                   start;
  logic                   memReady;
  logic                   memReadFlag;
  logic                   memWriteFlag;
  logic                   regWriteFlag;
  logic                   branchFlag;
  logic                   unconditionalBranchFlag;
  logic                   haltRequest;

  logic                   irWrite;
  logic                   aluEnable;
  logic                   memEnable;
  logic                   regWriteEnable;
  logic                   pcWriteEnable;
  logic [2:0]             state;
  logic                   halted;
  logic                   timeoutError;
  logic [COUNT_WIDTH-1:0] instrCount;
  logic [COUNT_WIDTH-1:0] cycleCount;

  modport master (
    input  start, memReady, memReadFlag, memWriteFlag,
    input  regWriteFlag, branchFlag,
    input  unconditionalBranchFlag, haltRequest,
    output irWrite, aluEnable, memEnable,
    output regWriteEnable, pcWriteEnable,
    output state, halted, timeoutError,
    output instrCount, cycleCount
  );

  modport slave (
    output start, memReady, memReadFlag, memWriteFlag,
    output regWriteFlag, branchFlag,
    output unconditionalBranchFlag, haltRequest,
    input  irWrite, aluEnable, memEnable,
    input  regWriteEnable, pcWriteEnable,
    input  state, halted, timeoutError,
    input  instrCount, cycleCount
  );

endinterface

// File: rtl/sequencer_wait_timer.sv
// Memory wait timer: counts stalled cycles in FETCH/MEMORY.
// Ports: clock_i, reset_i, active_i, ready_i -> expired_o.
module sequencer_wait_timer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int W = $clog2(MEM_TIMEOUT + 1) + 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         stall;

  // Any cycle outside a stall zeroes the count, so every
  // entry into FETCH or MEMORY starts from zero.
  assign stall     = active_i && !ready_i;
  assign cnt_d     = stall ? cnt_q + 1'b1 : '0;
  assign expired_o = stall && (cnt_q == W'(MEM_TIMEOUT));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer FSM with retire/cycle counters.
// Ports: clock, reset (async high), bus (master modport).
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_sequencer_if.master bus
);

  state_t                 state_q, state_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] instr_q, cycle_q;
  logic                   ir_we, alu_en, mem_en;
  logic                   rf_we, pc_we;
  logic                   waiting, expired, busy;

  assign waiting = is_wait(state_q);
  assign busy    = (state_q != S_IDLE) &&
                   (state_q != S_HALT);

  sequencer_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clock_i  (clock),
    .reset_i  (reset),
    .active_i (waiting),
    .ready_i  (bus.memReady),
    .expired_o(expired)
  );

  // Enables depend on the same-cycle memReady and decode
  // flags, so they are decoded alongside the next state.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    ir_we     = 1'b0;
    alu_en    = 1'b0;
    mem_en    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.memReady) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = bus.haltRequest ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (bus.branchFlag ||
            bus.unconditionalBranchFlag) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else if (bus.memReadFlag ||
                     bus.memWriteFlag) begin
          state_d = S_MEMORY;
        end else if (bus.regWriteFlag) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMORY: begin
        mem_en = 1'b1;
        if (bus.memReady) begin
          if (bus.memReadFlag) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timeout_q <= 1'b0;
      instr_q   <= '0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      if (pc_we) instr_q <= instr_q + 1'b1;
      if (busy)  cycle_q <= cycle_q + 1'b1;
    end
  end

  assign bus.irWrite        = ir_we;
  assign bus.aluEnable      = alu_en;
  assign bus.memEnable      = mem_en;
  assign bus.regWriteEnable = rf_we;
  assign bus.pcWriteEnable  = pc_we;
  assign bus.state          = state_q;
  assign bus.halted         = (state_q == S_HALT);
  assign bus.timeoutError   = timeout_q;
  assign bus.instrCount     = instr_q;
  assign bus.cycleCount     = cycle_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: expected state traces
// and retire cycles are queued per instruction and popped live.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int TO = MEM_TIMEOUT_DEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   st_lo = 0;
  int   st_hi = 0;
  int   mem_cnt = 0;
  int   rwe_cyc = 0;

  logic [2:0] exp_state_q[$];
  int         ret_q[$];

  multicycle_sequencer_if #(.COUNT_WIDTH(32)) mif ();
  multicycle_sequencer_if #(.COUNT_WIDTH(4))  wif ();

  multicycle_sequencer #(
    .MEM_TIMEOUT(TO), .COUNT_WIDTH(32)
  ) u_dut (
    .clock(clock), .reset(reset), .bus(mif)
  );

  multicycle_sequencer #(
    .MEM_TIMEOUT(TO), .COUNT_WIDTH(4)
  ) u_wrap (
    .clock(clock), .reset(reset), .bus(wif)
  );

  assign wif.start        = mif.start;
  assign wif.memReady     = mif.memReady;
  assign wif.memReadFlag  = mif.memReadFlag;
  assign wif.memWriteFlag = mif.memWriteFlag;
  assign wif.regWriteFlag = mif.regWriteFlag;
  assign wif.branchFlag   = mif.branchFlag;
  assign wif.unconditionalBranchFlag =
    mif.unconditionalBranchFlag;
  assign wif.haltRequest  = mif.haltRequest;

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {halt, branch, uncond, memRead, memWrite, regWrite}
  task automatic set_flags(input logic [5:0] f);
    {mif.haltRequest, mif.branchFlag,
     mif.unconditionalBranchFlag, mif.memReadFlag,
     mif.memWriteFlag, mif.regWriteFlag} = f;
  endtask

  task automatic push_st(input int n, input logic [2:0] s);
    repeat (n) exp_state_q.push_back(s);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    mif.start = 1'b0;
    mif.memReady = 1'b0;
    set_flags(6'b0);
    @(negedge clock);
    reset = 1'b0;
    st_lo = 0;
    st_hi = 0;
  endtask

  // Pulses start from IDLE, then walks the queued state trace;
  // memReady is low for cycles in [st_lo, st_hi).
  task automatic run(input string tag);
    logic [2:0] es;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    cyc     = 1;
    mem_cnt = 0;
    rwe_cyc = 0;
    while (exp_state_q.size() > 0) begin
      mif.memReady = !(cyc >= st_lo && cyc < st_hi);
      #1;
      es = exp_state_q.pop_front();
      chk($sformatf("%s state c%0d", tag, cyc),
          32'(mif.state), 32'(es));
      chk($sformatf("%s irWrite c%0d", tag, cyc),
          32'(mif.irWrite),
          32'((es == 3'd1) && mif.memReady));
      chk($sformatf("%s alu c%0d", tag, cyc),
          32'(mif.aluEnable), 32'(es == 3'd3));
      chk($sformatf("%s mem c%0d", tag, cyc),
          32'(mif.memEnable), 32'(es == 3'd4));
      chk($sformatf("%s rwe c%0d", tag, cyc),
          32'(mif.regWriteEnable), 32'(es == 3'd5));
      chk($sformatf("%s halted c%0d", tag, cyc),
          32'(mif.halted), 32'(es == 3'd6));
      if (mif.memEnable) mem_cnt++;
      if (mif.regWriteEnable) rwe_cyc = cyc;
      if (mif.pcWriteEnable) begin
        if (ret_q.size() == 0)
          chk($sformatf("%s spurious pcwe c%0d", tag, cyc),
              32'(mif.pcWriteEnable), 32'(0));
        else
          chk($sformatf("%s retire cycle", tag),
              32'(cyc), 32'(ret_q.pop_front()));
      end
      if (exp_state_q.size() > 0) begin
        tick();
        cyc++;
      end
    end
    chk($sformatf("%s missed retires", tag),
        32'(ret_q.size()), 32'(0));
    ret_q.delete();
  endtask

  initial begin
    mif.start    = 1'b0;
    mif.memReady = 1'b0;
    set_flags(6'b0);
    #2;
    chk("rst state", 32'(mif.state), 32'(0));
    chk("rst instr", mif.instrCount, 32'(0));
    chk("rst cycles", mif.cycleCount, 32'(0));
    chk("rst halted", 32'(mif.halted), 32'(0));
    chk("rst timeout", 32'(mif.timeoutError), 32'(0));
    chk("rst pcwe", 32'(mif.pcWriteEnable), 32'(0));
    chk("rst wrap instr", 32'(wif.instrCount), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    // ALU op with writeback
    set_flags(6'b000001);
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(1, 3'd5);
    push_st(1, 3'd1);
    ret_q.push_back(4);
    run("alu");
    chk("alu rwe cycle", 32'(rwe_cyc), 32'(4));
    chk("alu instr", mif.instrCount, 32'(1));
    chk("alu cycles", mif.cycleCount, 32'(4));

    // Load with three stalled MEMORY cycles
    do_reset();
    set_flags(6'b000101);
    st_lo = 4; st_hi = 7;
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(4, 3'd4);
    push_st(1, 3'd5); push_st(1, 3'd1);
    ret_q.push_back(8);
    run("load");
    chk("load mem cycles", 32'(mem_cnt), 32'(4));
    chk("load cycles", mif.cycleCount, 32'(8));
    chk("load instr", mif.instrCount, 32'(1));

    // Branch beats memWrite
    do_reset();
    set_flags(6'b010010);
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(1, 3'd1);
    ret_q.push_back(3);
    run("branch");
    chk("branch mem cycles", 32'(mem_cnt), 32'(0));

    // Unconditional branch
    do_reset();
    set_flags(6'b001000);
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(1, 3'd1);
    ret_q.push_back(3);
    run("ubranch");

    // Store retires from MEMORY
    do_reset();
    set_flags(6'b000010);
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(1, 3'd4);
    push_st(1, 3'd1);
    ret_q.push_back(4);
    run("store");

    // FETCH timeout
    do_reset();
    set_flags(6'b0);
    st_lo = 1; st_hi = 1000;
    push_st(TO + 1, 3'd1); push_st(1, 3'd6);
    run("fto");
    chk("fto error", 32'(mif.timeoutError), 32'(1));
    chk("fto cycles", mif.cycleCount, 32'(TO + 1));
    mif.start = 1'b1;
    tick(); tick();
    #1;
    chk("fto absorb", 32'(mif.state), 32'(6));
    chk("fto error held", 32'(mif.timeoutError), 32'(1));
    mif.start = 1'b0;

    // memReady arrives exactly at the limit cycle
    do_reset();
    st_lo = 1; st_hi = TO + 1;
    push_st(TO + 1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(1, 3'd1);
    ret_q.push_back(TO + 3);
    run("limit");
    chk("limit error", 32'(mif.timeoutError), 32'(0));

    // MEMORY timeout
    do_reset();
    set_flags(6'b000010);
    st_lo = 4; st_hi = 1000;
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(TO + 1, 3'd4);
    push_st(1, 3'd6);
    run("mto");
    chk("mto error", 32'(mif.timeoutError), 32'(1));
    chk("mto mem cycles", 32'(mem_cnt), 32'(TO + 1));

    // Halt request in DECODE
    do_reset();
    set_flags(6'b100000);
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd6);
    run("halt");
    mif.start = 1'b1;
    tick(); tick(); tick();
    #1;
    chk("halt absorb", 32'(mif.state), 32'(6));
    chk("halt instr", mif.instrCount, 32'(0));
    chk("halt error", 32'(mif.timeoutError), 32'(0));
    mif.start = 1'b0;

    // Reset in the middle of a stalled load
    do_reset();
    set_flags(6'b000101);
    st_lo = 4; st_hi = 1000;
    push_st(1, 3'd1); push_st(1, 3'd2);
    push_st(1, 3'd3); push_st(2, 3'd4);
    run("rstmem");
    #2;
    reset = 1'b1;
    #1;
    chk("rstmem state", 32'(mif.state), 32'(0));
    chk("rstmem pcwe", 32'(mif.pcWriteEnable), 32'(0));
    chk("rstmem memen", 32'(mif.memEnable), 32'(0));
    chk("rstmem instr", mif.instrCount, 32'(0));
    chk("rstmem cycles", mif.cycleCount, 32'(0));
    @(negedge clock);
    reset = 1'b0;
    tick(); tick();
    #1;
    chk("rstmem idle", 32'(mif.state), 32'(0));
    chk("rstmem idle pcwe", 32'(mif.pcWriteEnable), 32'(0));

    // Sixteen ALU retirements wrap the 4-bit counters
    do_reset();
    set_flags(6'b0);
    for (int i = 0; i < 16; i++) begin
      push_st(1, 3'd1); push_st(1, 3'd2);
      push_st(1, 3'd3);
      ret_q.push_back(3 * (i + 1));
    end
    push_st(1, 3'd1);
    run("wrap");
    chk("wrap instr4", 32'(wif.instrCount), 32'(0));
    chk("wrap cycles4", 32'(wif.cycleCount), 32'(0));
    chk("wrap instr32", mif.instrCount, 32'(16));
    chk("wrap cycles32", mif.cycleCount, 32'(48));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
